// File: rtl/service_arbiter_if.sv
// Purpose: bundle of service request, push, finish, display-value and display-scan signals for service_arbiter.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or one-cycle pulses.
// Ports: master drives the requests/values and observes the results; slave is the arbiter side.
interface service_arbiter_if;
  logic [3:0]  spdt_service;  // request switches, bit3 = service 1
  logic [4:0]  push;          // raw buttons u,d,l,r,m (bit0..bit4)
  logic [3:0]  finish;        // one-cycle done pulses, same order as spdt_service
  logic [63:0] num_bus;       // {svc1, svc2, svc3, svc4} 4-digit BCD values
  logic [15:0] current_time;  // shown when nothing is granted
  logic [3:0]  grant;         // one-hot or zero
  logic [19:0] push_gated;    // {svc1[4:0], svc2, svc3, svc4} push pulses
  logic [3:0]  an;            // one-hot digit enable, bit3 = leftmost
  logic [3:0]  digit_val;     // BCD nibble for the enabled digit
  logic        busy;          // arbiter not idle

  modport master (
    output spdt_service, push, finish, num_bus, current_time,
    input  grant, push_gated, an, digit_val, busy
  );

  modport slave (
    input  spdt_service, push, finish, num_bus, current_time,
    output grant, push_gated, an, digit_val, busy
  );
endinterface

// File: rtl/service_arbiter.sv
// Purpose: fixed-priority single-owner arbiter for four services, with push routing and a 4-digit display scan.
// Latency: grant 1 edge after request; push pulse 2 edges after first sample; release costs one idle cycle.
// Backpressure: none; a granted service holds ownership until it finishes or drops its switch.
// Ports: clk, resetn (sync, active-low), bus (service_arbiter_if.slave) carrying all request/result signals.
module service_arbiter #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input logic              clk,
  input logic              resetn,
  service_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      mask_set;
  logic [3:0]      eligible;
  logic [4:0]      s1_q, s2_q;
  logic [4:0]      pulse;
  logic [19:0]     pulse_fld_q, pulse_fld_d;
  logic [19:0]     push_gated_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     src;

  // Arbitration FSM. mask remembers services that finished and must drop
  // their switch before they may be granted again.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    mask_set = 4'b0000;
    eligible = bus.spdt_service & ~mask_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = GRANTED;
          if (eligible[3])      grant_d = 4'b1000;
          else if (eligible[2]) grant_d = 4'b0100;
          else if (eligible[1]) grant_d = 4'b0010;
          else                  grant_d = 4'b0001;
        end
      end
      GRANTED: begin
        // Only the owner's finish counts; a finish and a switch drop in the
        // same cycle both release, and the mask clear below wins.
        if ((|(bus.finish & grant_q)) || !(|(bus.spdt_service & grant_q))) begin
          state_d  = RELEASE;
          grant_d  = 4'b0000;
          mask_set = bus.finish & grant_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
    mask_d = (mask_q | mask_set) & bus.spdt_service;
  end

  // Rising-edge detect on the button samples; the pulse is routed using the
  // grant seen at the same edge, then registered once more to the output.
  always_comb begin
    pulse       = s1_q & ~s2_q;
    pulse_fld_d = {pulse & {5{grant_q[3]}}, pulse & {5{grant_q[2]}},
                   pulse & {5{grant_q[1]}}, pulse & {5{grant_q[0]}}};
  end

  // Display scan: prescaler wrap advances the digit index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_comb begin
    case (grant_q)
      4'b1000: src = bus.num_bus[63:48];
      4'b0100: src = bus.num_bus[47:32];
      4'b0010: src = bus.num_bus[31:16];
      4'b0001: src = bus.num_bus[15:0];
      default: src = bus.current_time;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 4'b0000;
      mask_q       <= 4'b0000;
      s1_q         <= 5'b0;
      s2_q         <= 5'b0;
      pulse_fld_q  <= 20'b0;
      push_gated_q <= 20'b0;
      presc_q      <= '0;
      idx_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mask_q       <= mask_d;
      s1_q         <= bus.push;
      s2_q         <= s1_q;
      pulse_fld_q  <= pulse_fld_d;
      push_gated_q <= pulse_fld_q;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.push_gated = push_gated_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.an         = 4'b1000 >> idx_q;
  assign bus.digit_val  = src[(3 - idx_q) * 4 +: 4];

endmodule

// File: tb/tb_service_arbiter.sv
module tb_service_arbiter;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  service_arbiter_if bus();

  service_arbiter #(.SCAN_DIV(SD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which service (1..4, 0 = none) owns the arbiter, a
  // one-cycle cool-down after release, and a per-service "finished" latch.
  int         owner   = 0;
  bit         cooling = 1'b0;
  bit         done [1:4];
  int         since   = 0;
  logic [4:0] ph [$];   // push sample per edge, newest first
  logic [3:0] gh [$];   // model grant after each edge, newest first

  function automatic logic [3:0] grant_of(int s);
    logic [3:0] g;
    g = 4'b0000;
    if (s != 0) g[4 - s] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] sw, fin;
    bit picked;
    sw  = bus.spdt_service;
    fin = bus.finish;
    if (!resetn) begin
      owner   = 0;
      cooling = 1'b0;
      for (int s = 1; s <= 4; s++) done[s] = 1'b0;
      since   = 0;
      ph.push_front(5'b0);
    end else begin
      since++;
      if (owner != 0) begin
        if (fin[4 - owner] || !sw[4 - owner]) begin
          if (fin[4 - owner]) done[owner] = 1'b1;
          owner   = 0;
          cooling = 1'b1;
        end
      end else if (cooling) begin
        cooling = 1'b0;
      end else begin
        picked = 1'b0;
        for (int s = 1; s <= 4; s++)
          if (!picked && sw[4 - s] && !done[s]) begin
            owner  = s;
            picked = 1'b1;
          end
      end
      for (int s = 1; s <= 4; s++) if (!sw[4 - s]) done[s] = 1'b0;
      ph.push_front(bus.push);
    end
    gh.push_front(grant_of(owner));
    if (ph.size() > 6) ph.delete(6);
    if (gh.size() > 6) gh.delete(6);
  endtask

  task automatic check_all();
    logic [19:0] pg;
    logic [15:0] src;
    int idx;
    pg = 20'b0;
    if (since >= 3)
      for (int s = 1; s <= 4; s++)
        if (gh[2][4 - s]) pg[(4 - s) * 5 +: 5] = ph[2] & ~ph[3];
    src = (owner == 0) ? bus.current_time : bus.num_bus[(4 - owner) * 16 +: 16];
    idx = (since / SD) % 4;
    chk("m_grant", bus.grant, grant_of(owner));
    chk("m_busy", bus.busy, (owner != 0) || cooling);
    chk("m_push_gated", bus.push_gated, pg);
    chk("m_an", bus.an, 4'b1000 >> idx);
    chk("m_digit", bus.digit_val, src[(3 - idx) * 4 +: 4]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [3:0] an_tab  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] dig_tab [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [3:0] got     [4];
  int pulses, pulse_at;

  initial begin
    for (int i = 0; i < 4; i++) begin
      ph.push_front(5'b0);
      gh.push_front(4'b0);
    end
    resetn           = 1'b0;
    bus.spdt_service = 4'b0000;
    bus.push         = 5'b0;
    bus.finish       = 4'b0000;
    bus.num_bus      = 64'h5678_4321_8765_0930;
    bus.current_time = 16'h1234;

    // Reset state
    step(); step();
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_an", bus.an, 4'b1000);
    chk("rst_digit", bus.digit_val, 4'h1);
    chk("rst_push_gated", bus.push_gated, 20'b0);
    resetn = 1'b1;

    // Priority grant, no preemption
    bus.spdt_service = 4'b0110; step();
    chk("grant_svc2", bus.grant, 4'b0100);
    chk("grant_busy", bus.busy, 1'b1);
    bus.spdt_service = 4'b1110; repeat (3) step();
    chk("no_preempt", bus.grant, 4'b0100);

    // Finish with switch held: release, idle, service 3 next, 2 stays masked
    bus.spdt_service = 4'b0110; step();
    bus.finish = 4'b0100; step();
    bus.finish = 4'b0000;
    chk("fin_release_grant", bus.grant, 4'b0000);
    chk("fin_release_busy", bus.busy, 1'b1);
    step();
    chk("fin_idle_busy", bus.busy, 1'b0);
    step();
    chk("fin_next_svc3", bus.grant, 4'b0010);
    bus.spdt_service = 4'b0100; step();
    repeat (4) step();
    chk("svc2_masked", bus.grant, 4'b0000);
    bus.spdt_service = 4'b0000; step();
    bus.spdt_service = 4'b0100; step();
    chk("svc2_unmasked", bus.grant, 4'b0100);
    bus.spdt_service = 4'b0000; repeat (3) step();

    // Held button on service 1 gives exactly one pulse two edges later
    bus.spdt_service = 4'b1000; step(); step();
    pulses = 0; pulse_at = -1;
    bus.push = 5'b00001;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) bus.push = 5'b0;
      step();
      if (bus.push_gated[15]) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      chk("push_other_bits", bus.push_gated & ~20'h08000, 20'b0);
    end
    chk("push_pulse_count", pulses, 1);
    chk("push_pulse_edge", pulse_at, 2);
    bus.spdt_service = 4'b0000; repeat (3) step();

    // Scan sequence of current_time with nothing granted
    resetn = 1'b0; step(); resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      chk("scan_an", bus.an, an_tab[(c / SD) % 4]);
      chk("scan_digit", bus.digit_val, dig_tab[(c / SD) % 4]);
    end

    // Service 4 display 0930
    bus.spdt_service = 4'b0001; step();
    chk("grant_svc4", bus.grant, 4'b0001);
    for (int i = 0; i < 4; i++) got[i] = 4'hf;
    for (int i = 0; i < 16; i++) begin
      step();
      for (int j = 0; j < 4; j++) if (bus.an == an_tab[j]) got[j] = bus.digit_val;
    end
    chk("disp_d0", got[0], 4'h0);
    chk("disp_d1", got[1], 4'h9);
    chk("disp_d2", got[2], 4'h3);
    chk("disp_d3", got[3], 4'h0);

    // Finish coinciding with switch drop: release, mask not left set
    bus.finish = 4'b0001; bus.spdt_service = 4'b0000; step();
    bus.finish = 4'b0000;
    chk("co_release_grant", bus.grant, 4'b0000);
    chk("co_release_busy", bus.busy, 1'b1);
    bus.spdt_service = 4'b0001; step();
    chk("co_idle_busy", bus.busy, 1'b0);
    step();
    chk("co_regrant_svc4", bus.grant, 4'b0001);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.spdt_service = 4'($urandom);
      bus.finish       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.push         = 5'($urandom);
      if ($urandom_range(0, 15) == 0) bus.current_time = 16'($urandom);
      step();
    end

    // Reset in mid-GRANTED
    bus.finish = 4'b0000; bus.push = 5'b0;
    bus.spdt_service = 4'b0000; repeat (3) step();
    bus.spdt_service = 4'b1000; step();
    chk("pre_rst_grant", bus.grant, 4'b1000);
    bus.push = 5'b00001; step();
    resetn = 1'b0; step();
    chk("mid_rst_grant", bus.grant, 4'b0000);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_push_gated", bus.push_gated, 20'b0);
    chk("mid_rst_an", bus.an, 4'b1000);
    chk("mid_rst_digit", bus.digit_val, bus.current_time[15:12]);
    resetn = 1'b1; bus.push = 5'b0; bus.spdt_service = 4'b0000;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/service_arbiter.md
SERVICE_ARBITER -- requirements
Module: service_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles each display digit is held; legal range is 2 or more.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 spdt_service  input  4  service request switches, level; bit3 = service 1 … bit0 = service 4.
REQ-005 push  input  5  raw push buttons: bit0 u, bit1 d, bit2 l, bit3 r, bit4 m.
REQ-006 finish  input  4  one-cycle done pulses, same bit order as spdt_service.
REQ-007 num_bus  input  64  display values {svc1, svc2, svc3, svc4}, 16 bits each, 4 BCD digits, leftmost digit in MSBs.
REQ-008 current_time  input  16  value shown when no service is granted.
REQ-009 grant  output  4  one-hot or zero; the bit order SHALL match spdt_service.
REQ-010 push_gated  output  20  per-service push pulses {svc1[4:0], svc2, svc3, svc4}.
REQ-011 an  output  4  one-hot active-high digit enable; bit3 = leftmost digit.
REQ-012 digit_val  output  4  BCD nibble for the digit enabled by an.
REQ-013 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANTED and RELEASE; grant SHALL be registered.
REQ-015 IDLE: with eligible = spdt_service & ~mask nonzero at edge k, the block SHALL go to GRANTED after edge k, with grant = the highest-priority eligible bit (service 1 highest).
REQ-016 GRANTED: grant SHALL hold; requests from other services SHALL NOT preempt it.
REQ-017 GRANTED: if finish[granted] = 1 at edge k, the block SHALL go to RELEASE with grant = 0 after edge k and set mask[granted].
REQ-018 GRANTED: if spdt_service[granted] = 0 at edge k, the block SHALL go to RELEASE with grant = 0 and leave mask unchanged.
REQ-019 If finish and the switch drop occur in the same cycle, REQ-017 and REQ-018 SHALL both apply: go to RELEASE, with the mask bit set and cleared per REQ-021.
REQ-020 RELEASE SHALL last exactly one cycle, then return to IDLE; the earliest new grant is after edge k+2.
REQ-021 Each mask bit SHALL clear on any edge where its spdt_service bit is 0; mask clearing SHALL take priority over setting.
REQ-022 finish bits of non-granted services SHALL be ignored.
REQ-023 Push conditioning: push SHALL be registered into s1, then s1 into s2; pulse = s1 & ~s2, registered into push_gated.
REQ-024 A push first sampled high at edge k SHALL produce a one-cycle pulse after edge k+2, only in the 5-bit field of the service granted at edge k+1; all other fields SHALL stay 0.
REQ-025 A held button SHALL produce exactly one pulse; with grant = 0, push_gated SHALL be all 0.
REQ-026 Display source SHALL be the granted service's num_bus slice, or current_time when grant = 0; the source SHALL switch combinationally with grant.
REQ-027 Scan: the prescaler SHALL count 0..SCAN_DIV-1; at wrap, the digit index SHALL advance 0→1→2→3→0.
REQ-028 Index 0 SHALL give an = 1000 with digit_val = src[15:12]; index 3 SHALL give an = 0001 with digit_val = src[3:0].
REQ-029 an SHALL always be exactly one-hot after reset.

Reset
REQ-030 With resetn = 0 at an edge, the block SHALL go after that edge to: state IDLE, grant 0, mask 0, s1/s2 0, push_gated 0, prescaler 0, index 0 (an = 1000), busy 0.
REQ-031 After reset, digit_val SHALL equal current_time[15:12].
REQ-032 Reset SHALL override every other event, including a reset in mid-GRANTED.
REQ-033 The first grant after reset release SHALL follow REQ-015 from the next edge.

Verification
REQ-034 The bench SHALL drive spdt_service = 0110 from IDLE and check grant = 0100 one edge later with busy = 1; then drive 1110 and check grant stays 0100 (no preemption).
REQ-035 The bench SHALL, with service 2 granted, pulse finish = 0100 with the switch held, and check: grant 0 next cycle, IDLE after that, service 2 never regranted until its switch is 0, and service 3 granted if its switch is high.
REQ-036 The bench SHALL, with service 1 granted, hold push = 00001 for 10 cycles, and check push_gated[15] pulses once, two edges after the first sample, and no other bit toggles.
REQ-037 The bench SHALL, with grant = 0, current_time = 16'h1234 and SCAN_DIV = 4, check an/digit_val sequence 1000/1, 0100/2, 0010/3, 0001/4, then 1000/1, each held 4 cycles.
REQ-038 The bench SHALL, with service 4 granted and num_bus[15:0] = 16'h0930, check that the displayed digits read 0,9,3,0.
REQ-039 The bench SHALL check that finish = 0001 coinciding with spdt_service[0] falling gives RELEASE and mask[0] = 0.
REQ-040 The bench SHALL assert resetn = 0 in mid-GRANTED and check that all outputs match REQ-030 one edge later.
